// File: rtl/axi_lite_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_cmd_arbiter
// Brief  : Round-robin arbiter sharing one axi_lite_master command port among
//          NREQ requesters, with a per-transaction timeout guard.
// Rev    : 1.0  initial release
// ============================================================================
module axi_lite_cmd_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_mode,
   input  logic [NREQ*AW-1:0]      req_addr,
   input  logic [NREQ*DW-1:0]      req_wdata,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [DW-1:0]           rsp_rdata,
   output logic                    rsp_err,
   output logic                    m_start,
   output logic                    m_mode,
   output logic [AW-1:0]           m_addr,
   output logic [DW-1:0]           m_wdata,
   input  logic [DW-1:0]           m_rdata,
   input  logic                    m_done,
   output logic                    busy,
   output logic [$clog2(NREQ)-1:0] grant_id
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WAIT_DONE = 2'd1;
   localparam logic [1:0] WAIT_LOW  = 2'd2;
   localparam logic [1:0] DRAIN     = 2'd3;

   localparam logic [CW-1:0]   c_cnt_last = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0]   c_cnt_one  = CW'(1);
   localparam logic [NREQ-1:0] c_one      = NREQ'(1);
   localparam logic [IW:0]     c_nreq     = (IW+1)'(NREQ);

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [IW-1:0]   r_last_grant;
   logic [CW-1:0]   r_cnt;

   logic            w_found;
   logic [IW-1:0]   w_winner;
   logic [IW:0]     w_idx;

   logic [NREQ-1:0] w_req_ready_nxt;
   logic [NREQ-1:0] w_rsp_valid_nxt;
   logic [DW-1:0]   w_rsp_rdata_nxt;
   logic            w_rsp_err_nxt;
   logic            w_m_start_nxt;
   logic            w_m_mode_nxt;
   logic [AW-1:0]   w_m_addr_nxt;
   logic [DW-1:0]   w_m_wdata_nxt;
   logic [IW-1:0]   w_grant_id_nxt;
   logic [IW-1:0]   w_last_grant_nxt;
   logic [CW-1:0]   w_cnt_nxt;

   // Search upward from the slot after the previous winner, wrapping at NREQ.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx = {1'b0, r_last_grant} + (IW+1)'(k);
         if (w_idx >= c_nreq) begin
            w_idx = w_idx - c_nreq;
         end
         if (!w_found && req_valid[w_idx[IW-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (m_done) begin
               w_state_nxt = WAIT_LOW;
            end else if (r_cnt == c_cnt_last) begin
               w_state_nxt = DRAIN;
            end
         end
         WAIT_LOW: begin
            if (!m_done) begin
               w_state_nxt = IDLE;
            end
         end
         DRAIN: begin
            if (m_done) begin
               w_state_nxt = WAIT_LOW;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_req_ready_nxt  = '0;
      w_rsp_valid_nxt  = '0;
      w_rsp_rdata_nxt  = '0;
      w_rsp_err_nxt    = 1'b0;
      w_m_start_nxt    = 1'b0;
      w_m_mode_nxt     = m_mode;
      w_m_addr_nxt     = m_addr;
      w_m_wdata_nxt    = m_wdata;
      w_grant_id_nxt   = grant_id;
      w_last_grant_nxt = r_last_grant;
      w_cnt_nxt        = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_req_ready_nxt  = c_one << w_winner;
               w_m_start_nxt    = 1'b1;
               w_m_mode_nxt     = req_mode[w_winner];
               w_m_addr_nxt     = req_addr[int'(w_winner)*AW +: AW];
               w_m_wdata_nxt    = req_wdata[int'(w_winner)*DW +: DW];
               w_grant_id_nxt   = w_winner;
               w_last_grant_nxt = w_winner;
               w_cnt_nxt        = '0;
            end
         end
         WAIT_DONE: begin
            // A done on the final count still wins over the timeout.
            if (m_done) begin
               w_rsp_valid_nxt = c_one << grant_id;
               w_rsp_rdata_nxt = m_mode ? '0 : m_rdata;
            end else if (r_cnt == c_cnt_last) begin
               w_rsp_valid_nxt = c_one << grant_id;
               w_rsp_err_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + c_cnt_one;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         req_ready    <= '0;
         rsp_valid    <= '0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         m_start      <= 1'b0;
         m_mode       <= 1'b0;
         m_addr       <= '0;
         m_wdata      <= '0;
         busy         <= 1'b0;
         grant_id     <= '0;
         r_last_grant <= IW'(NREQ - 1);
         r_cnt        <= '0;
      end else begin
         req_ready    <= w_req_ready_nxt;
         rsp_valid    <= w_rsp_valid_nxt;
         rsp_rdata    <= w_rsp_rdata_nxt;
         rsp_err      <= w_rsp_err_nxt;
         m_start      <= w_m_start_nxt;
         m_mode       <= w_m_mode_nxt;
         m_addr       <= w_m_addr_nxt;
         m_wdata      <= w_m_wdata_nxt;
         busy         <= (w_state_nxt != IDLE);
         grant_id     <= w_grant_id_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_cnt        <= w_cnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lite_cmd_arbiter
// Brief  : Self-checking bench for axi_lite_cmd_arbiter with a behavioural
//          master/slave and a rotation-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_lite_cmd_arbiter;

   localparam int NREQ    = 4;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              rstn;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_mode;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   rsp_valid;
   logic [DW-1:0]     rsp_rdata;
   logic              rsp_err;
   logic              m_start;
   logic              m_mode;
   logic [AW-1:0]     m_addr;
   logic [DW-1:0]     m_wdata;
   logic [DW-1:0]     m_rdata;
   logic              m_done;
   logic              busy;
   logic [1:0]        grant_id;

   typedef struct packed {
      logic          mode;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [NREQ-1:0] vec;
      logic [NREQ-1:0] pend;
      logic            start;
      txn_t            bus;
      txn_t            front;
      int              cyc;
   } grant_t;

   typedef struct packed {
      logic [NREQ-1:0] vec;
      logic [DW-1:0]   rdata;
      logic            err;
      logic [1:0]      gid;
      int              cyc;
   } rsp_t;

   txn_t   rq[NREQ][$];
   grant_t glog[$];
   rsp_t   rlog[$];
   int     slog[$];
   int     dlog[$];

   int            cyc;
   int            passed;
   int            total;
   logic          hang;
   logic          slv_active;
   int            slv_wait;
   int            slv_hold;
   int            overlap;
   logic [DW-1:0] slv_data;
   logic [DW-1:0] slv_mem[16];
   grant_t        e_g;
   rsp_t          e_r;
   int            e_id;

   axi_lite_cmd_arbiter #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_start(m_start), .m_mode(m_mode), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_done(m_done), .busy(busy), .grant_id(grant_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Environment: log DUT activity, model the master/slave, drive requesters.
   initial begin
      m_done = 1'b0; m_rdata = '0; req_valid = '0; req_mode = '0; req_addr = '0; req_wdata = '0;
      slv_active = 1'b0; slv_wait = 0; slv_hold = 0; overlap = 0; slv_data = '0;
      for (int i = 0; i < 16; i++) slv_mem[i] = '0;
      forever begin
         @(negedge clk);
         if (req_ready != '0) begin
            e_id = 0;
            for (int i = NREQ-1; i >= 0; i--) if (req_ready[i]) e_id = i;
            e_g.vec   = req_ready;
            e_g.pend  = req_valid;
            e_g.start = m_start;
            e_g.bus   = {m_mode, m_addr, m_wdata};
            e_g.front = (rq[e_id].size() > 0) ? rq[e_id][0] : '0;
            e_g.cyc   = cyc;
            glog.push_back(e_g);
            if (rq[e_id].size() > 0) void'(rq[e_id].pop_front());
         end
         if (rsp_valid != '0) begin
            e_r = {rsp_valid, rsp_rdata, rsp_err, grant_id, cyc};
            rlog.push_back(e_r);
         end
         if (m_start === 1'b1) slog.push_back(cyc);

         if (!rstn) begin
            m_done = 1'b0; slv_active = 1'b0; slv_hold = 0;
         end else begin
            if (m_start === 1'b1 && (slv_active || slv_hold > 0)) overlap++;
            if (slv_hold > 0) begin
               slv_hold--;
               if (slv_hold == 0) m_done = 1'b0;
            end else if (slv_active) begin
               if (!hang) begin
                  if (slv_wait > 0) slv_wait--;
                  else begin
                     m_done = 1'b1; m_rdata = slv_data; dlog.push_back(cyc); slv_active = 1'b0;
                     slv_hold = ($urandom_range(0, 1) == 0) ? 1 : int'($urandom_range(2, 3));
                  end
               end
            end else if (m_start === 1'b1) begin
               slv_active = 1'b1;
               slv_wait   = int'($urandom_range(0, 4));
               if (m_mode) begin
                  slv_mem[m_addr[5:2]] = m_wdata;
                  slv_data = $urandom;
               end else begin
                  slv_data = slv_mem[m_addr[5:2]];
               end
            end
         end

         for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
               req_valid[i] = 1'b1;
               req_mode[i]  = rq[i][0].mode;
               req_addr[i*AW +: AW]  = rq[i][0].addr;
               req_wdata[i*DW +: DW] = rq[i][0].wdata;
            end else begin
               req_valid[i] = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      glog.delete(); rlog.delete(); slog.delete(); dlog.delete();
      overlap = 0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      hang = 1'b0;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      repeat (3) step();
      rstn = 1'b1;
      clear_logs();
      step();
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      bit empty;
      ok = 1'b0;
      for (int n = 0; n < budget; n++) begin
         step();
         empty = 1'b1;
         for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) empty = 1'b0;
         if (empty && rlog.size() == glog.size() && !busy && !slv_active && slv_hold == 0 && !m_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) step();
      total++; if ({req_ready, rsp_valid, rsp_err, m_start, busy} !== '0) $display("FAIL reset_ctrl: got %h want 0", {req_ready, rsp_valid, rsp_err, m_start, busy}); else passed++;
      total++; if ({m_mode, m_addr, m_wdata} !== '0) $display("FAIL reset_mbus: got %h want 0", {m_mode, m_addr, m_wdata}); else passed++;
      total++; if (rsp_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata); else passed++;
      total++; if (grant_id !== 2'd0) $display("FAIL reset_gid: got %0d want 0", grant_id); else passed++;
      rstn = 1'b1;
      repeat (3) step();
      total++; if ({busy, m_start, req_ready} !== '0) $display("FAIL idle_quiet: got %h want 0", {busy, m_start, req_ready}); else passed++;
   endtask

   task automatic test_write_read();
      bit ok;
      grant_t g;
      rsp_t r;
      do_reset();
      rq[0].push_back({1'b1, 32'h10, 32'hDEADBAAD});
      wait_idle(100, ok);
      g = (glog.size() > 0) ? glog[0] : '0;
      r = (rlog.size() > 0) ? rlog[0] : '0;
      total++; if (ok !== 1'b1) $display("FAIL wr_idle: got %0d want 1", ok); else passed++;
      total++; if (g.vec !== 4'b0001) $display("FAIL wr_ready: got %b want 0001", g.vec); else passed++;
      total++; if (g.start !== 1'b1) $display("FAIL wr_start_with_ready: got %b want 1", g.start); else passed++;
      total++; if (g.bus !== {1'b1, 32'h10, 32'hDEADBAAD}) $display("FAIL wr_mbus: got %h want %h", g.bus, {1'b1, 32'h10, 32'hDEADBAAD}); else passed++;
      total++; if (slog.size() !== 1) $display("FAIL wr_start_cycles: got %0d want 1", slog.size()); else passed++;
      total++; if (slv_mem[4] !== 32'hDEADBAAD) $display("FAIL wr_mem4: got %h want deadbaad", slv_mem[4]); else passed++;
      total++; if (rlog.size() !== 1) $display("FAIL wr_rsp_count: got %0d want 1", rlog.size()); else passed++;
      total++; if ({r.vec, r.err, r.rdata} !== {4'b0001, 1'b0, 32'h0}) $display("FAIL wr_rsp: got %h want %h", {r.vec, r.err, r.rdata}, {4'b0001, 1'b0, 32'h0}); else passed++;
      total++; if (dlog.size() == 0 || r.cyc !== dlog[0] + 1) $display("FAIL wr_done_latency: got %0d want done+1", r.cyc); else passed++;

      rq[2].push_back({1'b0, 32'h10, 32'h0});
      wait_idle(100, ok);
      r = (rlog.size() > 1) ? rlog[1] : '0;
      total++; if (ok !== 1'b1) $display("FAIL rd_idle: got %0d want 1", ok); else passed++;
      total++; if (r.vec !== 4'b0100) $display("FAIL rd_rsp_vec: got %b want 0100", r.vec); else passed++;
      total++; if (r.rdata !== 32'hDEADBAAD) $display("FAIL rd_rdata: got %h want deadbaad", r.rdata); else passed++;
      total++; if (r.err !== 1'b0) $display("FAIL rd_err: got %b want 0", r.err); else passed++;
   endtask

   task automatic test_all_four();
      bit ok;
      logic [NREQ-1:0] ev;
      do_reset();
      for (int i = 0; i < NREQ; i++) rq[i].push_back({1'b1, 32'(i*4), $urandom});
      wait_idle(200, ok);
      total++; if (ok !== 1'b1) $display("FAIL all4_idle: got %0d want 1", ok); else passed++;
      total++; if (glog.size() !== 4 || rlog.size() !== 4) $display("FAIL all4_counts: got %0d/%0d want 4/4", glog.size(), rlog.size()); else passed++;
      for (int k = 0; k < glog.size() && k < rlog.size(); k++) begin
         ev = '0; ev[k % NREQ] = 1'b1;
         total++; if (glog[k].vec !== ev) $display("FAIL all4_grant%0d: got %b want %b", k, glog[k].vec, ev); else passed++;
         total++; if (rlog[k].vec !== ev) $display("FAIL all4_rsp%0d: got %b want %b", k, rlog[k].vec, ev); else passed++;
      end
      total++; if (overlap !== 0) $display("FAIL all4_overlap: got %0d want 0", overlap); else passed++;
      for (int k = 1; k < slog.size(); k++) begin
         total++; if (slog[k] - slog[k-1] < 4) $display("FAIL all4_spacing%0d: got %0d want >=4", k, slog[k] - slog[k-1]); else passed++;
      end
   endtask

   task automatic test_rr_hold();
      bit ok;
      int seq[6];
      logic [NREQ-1:0] ev;
      seq = '{1, 3, 1, 3, 1, 3};
      do_reset();
      for (int n = 0; n < 3; n++) begin
         rq[1].push_back({1'b0, 32'(n*8), 32'h0});
         rq[3].push_back({1'b1, 32'(n*8 + 4), $urandom});
      end
      wait_idle(300, ok);
      total++; if (ok !== 1'b1 || glog.size() !== 6) $display("FAIL rr_count: got %0d want 6", glog.size()); else passed++;
      for (int k = 0; k < 6 && k < glog.size(); k++) begin
         ev = '0; ev[seq[k]] = 1'b1;
         total++; if (glog[k].vec !== ev) $display("FAIL rr_grant%0d: got %b want %b", k, glog[k].vec, ev); else passed++;
      end
   endtask

   task automatic test_random();
      bit ok;
      int last;
      int expw;
      int idx;
      logic [NREQ-1:0] ev;
      logic [DW-1:0] ref_mem[16];
      logic [DW-1:0] exp_rdata;
      grant_t g;
      do_reset();
      for (int i = 0; i < 16; i++) ref_mem[i] = slv_mem[i];
      for (int n = 0; n < 40; n++) begin
         rq[$urandom_range(0, NREQ-1)].push_back({1'($urandom_range(0, 1)), 32'($urandom_range(0, 15) * 4), $urandom});
         repeat ($urandom_range(0, 6)) step();
      end
      wait_idle(3000, ok);
      total++; if (ok !== 1'b1) $display("FAIL rnd_idle: got %0d want 1", ok); else passed++;
      total++; if (glog.size() !== 40 || rlog.size() !== 40) $display("FAIL rnd_counts: got %0d/%0d want 40/40", glog.size(), rlog.size()); else passed++;
      total++; if (overlap !== 0) $display("FAIL rnd_overlap: got %0d want 0", overlap); else passed++;
      last = NREQ - 1;
      for (int k = 0; k < glog.size(); k++) begin
         g = glog[k];
         expw = -1;
         for (int j = 1; j <= NREQ; j++) begin
            idx = (last + j) % NREQ;
            if (expw < 0 && g.pend[idx]) expw = idx;
         end
         ev = '0;
         if (expw >= 0) ev[expw] = 1'b1;
         total++; if (g.vec !== ev) $display("FAIL rnd_grant%0d: got %b want %b", k, g.vec, ev); else passed++;
         total++; if ({g.start, g.bus} !== {1'b1, g.front}) $display("FAIL rnd_mbus%0d: got %h want %h", k, {g.start, g.bus}, {1'b1, g.front}); else passed++;
         if (expw >= 0) last = expw;
         exp_rdata = g.front.mode ? '0 : ref_mem[g.front.addr[5:2]];
         if (g.front.mode) ref_mem[g.front.addr[5:2]] = g.front.wdata;
         if (k < rlog.size() && k < dlog.size()) begin
            total++; if ({rlog[k].vec, 2'(rlog[k].gid)} !== {ev, 2'(last)}) $display("FAIL rnd_rsp_id%0d: got %b/%0d want %b/%0d", k, rlog[k].vec, rlog[k].gid, ev, last); else passed++;
            total++; if ({rlog[k].err, rlog[k].rdata} !== {1'b0, exp_rdata}) $display("FAIL rnd_rdata%0d: got %h want %h", k, {rlog[k].err, rlog[k].rdata}, {1'b0, exp_rdata}); else passed++;
            total++; if (rlog[k].cyc !== dlog[k] + 1) $display("FAIL rnd_latency%0d: got %0d want %0d", k, rlog[k].cyc, dlog[k] + 1); else passed++;
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      rsp_t r;
      do_reset();
      hang = 1'b1;
      rq[0].push_back({1'b0, 32'h20, 32'h0});
      repeat (3) step();
      rq[1].push_back({1'b1, 32'h24, 32'h1234});
      for (int n = 0; n < 60 && rlog.size() == 0; n++) step();
      r = (rlog.size() > 0) ? rlog[0] : '0;
      total++; if (rlog.size() !== 1) $display("FAIL to_rsp_count: got %0d want 1", rlog.size()); else passed++;
      total++; if ({r.vec, r.err, r.rdata} !== {4'b0001, 1'b1, 32'h0}) $display("FAIL to_rsp: got %h want %h", {r.vec, r.err, r.rdata}, {4'b0001, 1'b1, 32'h0}); else passed++;
      total++; if (slog.size() == 0 || r.cyc - slog[0] !== TIMEOUT) $display("FAIL to_latency: got %0d want %0d", (slog.size() > 0) ? r.cyc - slog[0] : -1, TIMEOUT); else passed++;
      repeat (10) step();
      total++; if (glog.size() !== 1 || slog.size() !== 1) $display("FAIL to_drain_hold: got %0d grants want 1", glog.size()); else passed++;
      total++; if (rlog.size() !== 1) $display("FAIL to_drain_rsp: got %0d want 1", rlog.size()); else passed++;
      hang = 1'b0;
      wait_idle(100, ok);
      total++; if (ok !== 1'b1 || glog.size() !== 2) $display("FAIL to_resume: got %0d grants want 2", glog.size()); else passed++;
      total++; if (glog.size() < 2 || glog[1].vec !== 4'b0010) $display("FAIL to_next_grant: got %b want 0010", (glog.size() > 1) ? glog[1].vec : 4'b0); else passed++;
      total++; if (glog.size() < 2 || dlog.size() == 0 || glog[1].cyc <= dlog[0]) $display("FAIL to_grant_after_done: got %0d want >%0d", (glog.size() > 1) ? glog[1].cyc : -1, (dlog.size() > 0) ? dlog[0] : -1); else passed++;
      total++; if (rlog.size() < 2 || {rlog[1].vec, rlog[1].err} !== {4'b0010, 1'b0}) $display("FAIL to_next_rsp: got %h want 4", (rlog.size() > 1) ? {rlog[1].vec, rlog[1].err} : 5'h0); else passed++;
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset();
      hang = 1'b1;
      rq[1].push_back({1'b1, 32'h30, 32'hA5A5_0F0F});
      for (int n = 0; n < 20 && glog.size() == 0; n++) step();
      repeat (3) step();
      total++; if ({busy, grant_id, m_mode} !== {1'b1, 2'd1, 1'b1}) $display("FAIL ar_pre: got %h want %h", {busy, grant_id, m_mode}, {1'b1, 2'd1, 1'b1}); else passed++;
      #1 rstn = 1'b0;
      #1;
      total++; if ({req_ready, rsp_valid, rsp_err, m_start, busy, grant_id} !== '0) $display("FAIL ar_ctrl: got %h want 0", {req_ready, rsp_valid, rsp_err, m_start, busy, grant_id}); else passed++;
      total++; if ({m_mode, m_addr, m_wdata, rsp_rdata} !== '0) $display("FAIL ar_data: got %h want 0", {m_mode, m_addr, m_wdata, rsp_rdata}); else passed++;
      hang = 1'b0;
      for (int i = 0; i < NREQ; i++) rq[i].delete();
      rq[2].push_back({1'b0, 32'h30, 32'h0});
      rq[0].push_back({1'b0, 32'h34, 32'h0});
      clear_logs();
      repeat (2) step();
      rstn = 1'b1;
      wait_idle(100, ok);
      total++; if (ok !== 1'b1 || glog.size() !== 2) $display("FAIL ar_count: got %0d want 2", glog.size()); else passed++;
      total++; if (glog.size() < 2 || {glog[0].vec, glog[1].vec} !== 8'b0001_0100) $display("FAIL ar_order: got %h want 14", (glog.size() > 1) ? {glog[0].vec, glog[1].vec} : 8'h0); else passed++;
      total++; if (rlog.size() !== 2 || rlog[0].err !== 1'b0) $display("FAIL ar_no_stale_rsp: got %0d rsp want 2", rlog.size()); else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      hang   = 1'b0;
      rstn   = 1'b0;
      test_reset();
      test_write_read();
      test_all_four();
      test_rr_hold();
      test_random();
      test_timeout();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
